// File: rtl/lvl_flush_fifo_if.sv
// Valid/ready bus plus level, threshold and watermark sideband for lvl_flush_fifo.
// The master drives writes, read-ready and control; the slave is the FIFO itself.
interface lvl_flush_fifo_if #(
    parameter int DP = 8,
    parameter int DW = 32
) ();
    localparam int CW = $clog2(DP + 1);

    logic          flush;
    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] i_dat;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] o_dat;
    logic [CW-1:0] afull_thr;
    logic [CW-1:0] aempty_thr;
    logic [CW-1:0] lvl;
    logic          afull;
    logic          aempty;
    logic [CW-1:0] wm;
    logic          wm_clr;

    modport master (
        output flush, i_vld, i_dat, o_rdy, afull_thr, aempty_thr, wm_clr,
        input  i_rdy, o_vld, o_dat, lvl, afull, aempty, wm
    );

    modport slave (
        input  flush, i_vld, i_dat, o_rdy, afull_thr, aempty_thr, wm_clr,
        output i_rdy, o_vld, o_dat, lvl, afull, aempty, wm
    );
endinterface

// File: rtl/lvl_flush_fifo.sv
// Register-file FIFO with one-hot pointers, occupancy flags, synchronous flush
// and a high-watermark monitor.
module lvl_flush_fifo #(
    parameter int DP   = 8,
    parameter int DW   = 32,
    parameter bit MSKO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lvl_flush_fifo_if.slave      bus
);
    localparam int            CW   = $clog2(DP + 1);
    localparam logic [CW-1:0] DP_C = CW'(DP);
    localparam logic [DP-1:0] PTR0 = DP'(1);

    logic [DW-1:0] r_mem [DP];
    logic [DP-1:0] r_wptr;
    logic [DP-1:0] r_rptr;
    logic [CW-1:0] r_lvl;
    logic [CW-1:0] r_wm;

    logic          w_irdy;
    logic          w_ovld;
    logic          w_wen;
    logic          w_ren;
    logic [CW-1:0] w_lvl_nxt;
    logic [DW-1:0] w_head;

    // Ready/valid never cross-depend, so a full FIFO cannot accept on a pop cycle.
    assign w_irdy = (r_lvl != DP_C) & ~bus.flush;
    assign w_ovld = (r_lvl != '0) & ~bus.flush;
    assign w_wen  = bus.i_vld & w_irdy;
    assign w_ren  = w_ovld & bus.o_rdy;

    always_comb begin
        w_lvl_nxt = r_lvl;
        if (bus.flush)
            w_lvl_nxt = '0;
        else if (w_wen & ~w_ren)
            w_lvl_nxt = r_lvl + CW'(1);
        else if (w_ren & ~w_wen)
            w_lvl_nxt = r_lvl - CW'(1);
    end

    always_comb begin
        w_head = '0;
        for (int i = 0; i < DP; i++)
            if (r_rptr[i])
                w_head = w_head | r_mem[i];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DP; i++)
            if (w_wen & r_wptr[i])
                r_mem[i] <= bus.i_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= PTR0;
            r_rptr <= PTR0;
            r_lvl  <= '0;
            r_wm   <= '0;
        end else begin
            if (bus.flush) begin
                r_wptr <= PTR0;
                r_rptr <= PTR0;
            end else begin
                if (w_wen)
                    r_wptr <= {r_wptr[DP-2:0], r_wptr[DP-1]};
                if (w_ren)
                    r_rptr <= {r_rptr[DP-2:0], r_rptr[DP-1]};
            end
            r_lvl <= w_lvl_nxt;
            if (bus.wm_clr)
                r_wm <= w_lvl_nxt;
            else if (w_lvl_nxt > r_wm)
                r_wm <= w_lvl_nxt;
        end
    end

    assign bus.i_rdy  = w_irdy;
    assign bus.o_vld  = w_ovld;
    assign bus.o_dat  = (MSKO && !w_ovld) ? '0 : w_head;
    assign bus.lvl    = r_lvl;
    assign bus.afull  = (r_lvl >= bus.afull_thr);
    assign bus.aempty = (r_lvl <= bus.aempty_thr);
    assign bus.wm     = r_wm;
endmodule

// File: doc/lvl_flush_fifo.md
Name: lvl_flush_fifo

Overview:
Parametrised synchronous valid/ready FIFO that generalises the single-rate datapath FIFO with occupancy reporting, programmable almost-full/almost-empty thresholds, a synchronous flush and a high-watermark monitor. It sits between the QSPI command/data engines and bus-side logic. Producers can throttle on almost-full, and software can size buffers from the watermark. Storage is a register file with one-hot read/write pointers.

Parameters:
DP, 8, FIFO depth in entries; legal values 2..256.
DW, 32, data width in bits.
MSKO, 0, 1 = o_dat forced to zero while o_vld is 0; 0 = o_dat unmasked.
CW, derived as $clog2(DP+1), width of the level, threshold and watermark fields (localparam).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous discard of all contents.
i_vld  in  1  write valid.
i_rdy  out  1  write ready.
i_dat  in  DW  write data.
o_vld  out  1  read valid.
o_rdy  in  1  read ready.
o_dat  out  DW  read data (head entry).
afull_thr  in  CW  almost-full threshold, quasi-static.
aempty_thr  in  CW  almost-empty threshold, quasi-static.
lvl  out  CW  current occupancy, 0..DP.
afull  out  1  lvl >= afull_thr.
aempty  out  1  lvl <= aempty_thr.
wm  out  CW  maximum lvl reached since reset or the last wm_clr.
wm_clr  in  1  synchronous watermark reload.

Behaviour:
- Reset (async assert, sync-safe deassert by upstream):
  - Pointers point to entry 0; lvl=0, wm=0.
  - o_vld=0; i_rdy=1 from the first cycle after reset.
  - afull=(afull_thr==0); aempty=1.
  - Storage is not reset.
- Handshakes:
  - wen = i_vld & i_rdy; ren = o_vld & o_rdy.
  - i_rdy = (lvl != DP) & ~flush.
  - i_rdy never depends on o_rdy, so a full FIFO does not accept on a pop cycle.
  - o_vld = (lvl != 0) & ~flush.
  - o_dat is the head entry, valid whenever o_vld=1; it is held stable while o_vld & ~o_rdy.
- Latency: data written in cycle N is presented with o_vld=1 in cycle N+1. No combinational i_dat->o_dat bypass.
- Level:
  - wen & ~ren: lvl+1.
  - ren & ~wen: lvl-1.
  - Both or neither: lvl unchanged.
  - lvl never exceeds DP and never underflows; the handshake rules guarantee this.
- Pointers: one-hot, advance on wen/ren respectively, wrap from entry DP-1 to entry 0.
- Flush:
  - Highest priority. In a flush cycle, i_rdy=0 and o_vld=0, so no transfer occurs.
  - Next cycle: both pointers at entry 0, lvl=0.
  - Storage is untouched. wm is not cleared.
  - Back-to-back flush cycles are legal.
- Flags: afull and aempty are combinational compares on the registered lvl, so they change in the cycle after the causing transfer. With afull_thr=0, afull is stuck at 1. With aempty_thr>=DP, aempty is stuck at 1.
- Watermark:
  - lvl_nxt is the value lvl takes at the next edge.
  - Each cycle, wm <= max(wm, lvl_nxt).
  - wm_clr: wm <= lvl_nxt, taking priority over the max update.
  - A flush cycle loads lvl_nxt=0 into the compare, so it only affects wm when combined with wm_clr.
- Reset mid-operation: all state returns to reset values immediately; data in flight is lost.

Test Plan:
- DP=4, DW=8: write 0x11,0x22,0x33,0x44 with o_rdy=0 -> lvl 1,2,3,4; i_rdy=0 at lvl 4; 5th write stalls; then o_rdy=1 -> reads 0x11..0x44 in order, one per cycle, lvl returns to 0, o_vld=0.
- Continuous push/pop with i_vld=o_rdy=1 for 20 cycles from lvl=2 -> lvl stays 2; output sequence equals input sequence delayed by 2 transfers; pointers wrap 5 times without loss.
- Full with o_rdy=1 and i_vld=1 -> cycle 1 pops only (i_rdy=0), lvl goes 4->3; next cycle push and pop, lvl stays 3.
- afull_thr=3, aempty_thr=1: fill 0->4 then drain -> afull rises the cycle after lvl reaches 3; aempty is 1 at lvl 0,1 and 0 at lvl 2..4.
- Fill to 3, assert flush one cycle with i_vld=o_rdy=1 -> no transfer; next cycle lvl=0, o_vld=0, wm=3. Write 0xAB -> o_dat=0xAB, proving the flushed data is gone.
- wm reached 4, then drain to 1 and pulse wm_clr -> wm=1. Assert rst_n=0 mid-burst at lvl=2 -> lvl=0, o_vld=0, wm=0 immediately.
